seg_dynamic_hex: RTL and testbench

//   Multiplexed N-digit hex seven-segment driver; successor to the single-digit static driver.

---
 rtl/seg_dynamic_hex.sv | 157 +++++++++++++++
 tb/tb_seg_dynamic_hex.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/seg_dynamic_hex.sv
// Multiplexed N-digit hex seven-segment driver with frame-synchronous updates and inter-digit blanking.
// Optional build macro SEG_BLANK_LZ_EN: leading-zero digits (except digit 0) show no segments.
module seg_dynamic_hex #(
  parameter int unsigned DIGIT_NUM    = 6,
  parameter logic [31:0] SCAN_CNT_MAX = 32'd49_999,
  parameter logic [15:0] BLANK_CYC    = 16'd500
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic [4*DIGIT_NUM-1:0] data_in,
  input  logic [DIGIT_NUM-1:0]   dp_in,
  input  logic                   data_vld,
  output logic                   data_rdy,
  input  logic                   disp_en,
  output logic [DIGIT_NUM-1:0]   sel,
  output logic [7:0]             seg
);

  localparam int unsigned      IDX_W    = (DIGIT_NUM > 1) ? $clog2(DIGIT_NUM) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGIT_NUM - 1);

  typedef enum logic {
    ST_READY,
    ST_PEND
  } upd_state_t;

  upd_state_t state, state_nxt;

  logic [31:0]            scan_cnt;
  logic [IDX_W-1:0]       idx;
  logic                   cnt_wrap;
  logic                   frame_end;
  logic                   accept;
  logic                   commit;
  logic [4*DIGIT_NUM-1:0] shadow_data;
  logic [DIGIT_NUM-1:0]   shadow_dp;
  logic [4*DIGIT_NUM-1:0] act_data;
  logic [DIGIT_NUM-1:0]   act_dp;
  logic [3:0]             cur_nib;
  logic                   cur_dp;
  logic                   cur_blank_lz;
  logic [6:0]             cur_glyph;
  logic                   slot_dark;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = 7'h40;
      4'h1: g = 7'h79;
      4'h2: g = 7'h24;
      4'h3: g = 7'h30;
      4'h4: g = 7'h19;
      4'h5: g = 7'h12;
      4'h6: g = 7'h02;
      4'h7: g = 7'h78;
      4'h8: g = 7'h00;
      4'h9: g = 7'h10;
      4'hA: g = 7'h08;
      4'hB: g = 7'h03;
      4'hC: g = 7'h46;
      4'hD: g = 7'h21;
      4'hE: g = 7'h06;
      default: g = 7'h0E;
    endcase
    return g;
  endfunction

  assign cnt_wrap  = (scan_cnt == SCAN_CNT_MAX);
  assign frame_end = cnt_wrap && (idx == IDX_LAST);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else if (cnt_wrap) begin
      scan_cnt <= '0;
      idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      scan_cnt <= scan_cnt + 32'd1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= ST_READY;
    else         state <= state_nxt;
  end

  // A capture coinciding with frame_end lands in ST_PEND only afterwards,
  // so its transfer naturally waits for the following frame_end.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    commit    = 1'b0;
    case (state)
      ST_READY: begin
        if (data_vld) begin
          accept    = 1'b1;
          state_nxt = ST_PEND;
        end
      end
      ST_PEND: begin
        if (frame_end) begin
          commit    = 1'b1;
          state_nxt = ST_READY;
        end
      end
      default: state_nxt = ST_READY;
    endcase
  end

  assign data_rdy = (state == ST_READY);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      shadow_data <= '0;
      shadow_dp   <= '0;
      act_data    <= '0;
      act_dp      <= '0;
    end else begin
      if (accept) begin
        shadow_data <= data_in;
        shadow_dp   <= dp_in;
      end
      if (commit) begin
        act_data <= shadow_data;
        act_dp   <= shadow_dp;
      end
    end
  end

  always_comb begin
    cur_nib = act_data[4*int'(idx) +: 4];
    cur_dp  = act_dp[idx];
`ifdef SEG_BLANK_LZ_EN
    // Blank when this digit and everything above it is zero; digit 0 always shows.
    cur_blank_lz = (idx != '0) && ((act_data >> (4*int'(idx))) == '0);
`else
    cur_blank_lz = 1'b0;
`endif
    cur_glyph = cur_blank_lz ? 7'h7F : hex_to_seg(cur_nib);
    slot_dark = !disp_en || (scan_cnt < {16'd0, BLANK_CYC});
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sel <= '1;
      seg <= '1;
    end else if (slot_dark) begin
      sel <= '1;
      seg <= '1;
    end else begin
      sel <= ~(DIGIT_NUM'(1) << idx);
      seg <= {~cur_dp, cur_glyph};
    end
  end

endmodule

// File: tb/tb_seg_dynamic_hex.sv
// Self-checking bench for seg_dynamic_hex: cycle-count based reference model plus literal checks.
module tb_seg_dynamic_hex;

  localparam int DN   = 4;
  localparam int SMAX = 9;
  localparam int BLK  = 2;
  localparam int SLOT = SMAX + 1;

  logic          sys_clk = 1'b0;
  logic          sys_rst;
  logic [4*DN-1:0] data_in;
  logic [DN-1:0] dp_in;
  logic          data_vld;
  logic          data_rdy;
  logic          disp_en;
  logic [DN-1:0] sel;
  logic [7:0]    seg;

  seg_dynamic_hex #(
    .DIGIT_NUM   (DN),
    .SCAN_CNT_MAX(32'(SMAX)),
    .BLANK_CYC   (16'(BLK))
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .data_in (data_in),
    .dp_in   (dp_in),
    .data_vld(data_vld),
    .data_rdy(data_rdy),
    .disp_en (disp_en),
    .sel     (sel),
    .seg     (seg)
  );

  always #5 sys_clk = ~sys_clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: position in the scan derived from cycles since reset.
  logic [6:0]      dec_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  int              m_n;
  bit              m_rdy;
  logic [4*DN-1:0] m_shadow, m_act;
  logic [DN-1:0]   m_sdp, m_adp;
  logic [DN-1:0]   exp_sel;
  logic [7:0]      exp_seg;

  initial begin
    int         pos, d;
    logic [3:0] nib;
    logic [6:0] g;
    forever begin
      @(posedge sys_clk);
      if (sys_rst) begin
        m_n = 0; m_rdy = 1'b1;
        m_shadow = '0; m_sdp = '0; m_act = '0; m_adp = '0;
        exp_sel = '1; exp_seg = 8'hFF;
      end else begin
        pos = m_n % SLOT;
        d   = (m_n / SLOT) % DN;
        if (pos < BLK || !disp_en) begin
          exp_sel = '1; exp_seg = 8'hFF;
        end else begin
          exp_sel = '1;
          exp_sel[d] = 1'b0;
          nib = m_act[4*d +: 4];
          g = dec_tab[nib];
`ifdef SEG_BLANK_LZ_EN
          if (d != 0 && (m_act >> (4*d)) == 0) g = 7'h7F;
`endif
          exp_seg = {~m_adp[d], g};
        end
        if (m_rdy && data_vld) begin
          m_shadow = data_in; m_sdp = dp_in; m_rdy = 1'b0;
        end else if (!m_rdy && (m_n % (SLOT*DN)) == SLOT*DN - 1) begin
          m_act = m_shadow; m_adp = m_sdp; m_rdy = 1'b1;
        end
        m_n++;
      end
    end
  end

  initial forever begin
    @(negedge sys_clk);
    if (chk_on) begin
      check("model_sel", 32'(sel), 32'(exp_sel));
      check("model_seg", 32'(seg), 32'(exp_seg));
      check("model_rdy", 32'(data_rdy), 32'(m_rdy));
    end
  end

  task automatic pulse_vld(input logic [4*DN-1:0] d, input logic [DN-1:0] p);
    data_in = d; dp_in = p; data_vld = 1'b1;
    @(negedge sys_clk);
    data_vld = 1'b0;
  endtask

  task automatic wait_rdy(input string name);
    for (int i = 0; i < 200; i++) begin
      if (data_rdy) break;
      @(negedge sys_clk);
    end
    check(name, 32'(data_rdy), 32'd1);
  endtask

  initial begin
    sys_rst = 1'b1; data_in = '0; dp_in = '0; data_vld = 1'b0; disp_en = 1'b1;
    @(negedge sys_clk);
    chk_on = 1'b1;
    repeat (2) @(negedge sys_clk);
    check("rst_sel", 32'(sel), 32'hF);
    check("rst_seg", 32'(seg), 32'hFF);
    check("rst_rdy", 32'(data_rdy), 32'd1);
    sys_rst = 1'b0;
    repeat (7) @(negedge sys_clk);

    pulse_vld(16'h1A3F, 4'b0100);
    check("rdy_low_after_vld", 32'(data_rdy), 32'd0);
    pulse_vld(16'hFFFF, 4'b1111);
    wait_rdy("rdy_return_1");
    for (int k = 1; k <= 33; k++) begin
      @(negedge sys_clk);
      case (k)
        1:  begin check("blank_sel", 32'(sel), 32'hF); check("blank_seg", 32'(seg), 32'hFF); end
        3:  begin check("d0_sel", 32'(sel), 32'hE); check("d0_seg", 32'(seg), 32'h8E); end
        5:  disp_en = 1'b0;
        6:  begin check("dis_sel", 32'(sel), 32'hF); check("dis_seg", 32'(seg), 32'hFF); disp_en = 1'b1; end
        7:  begin check("resume_sel", 32'(sel), 32'hE); check("resume_seg", 32'(seg), 32'h8E); end
        13: begin check("d1_sel", 32'(sel), 32'hD); check("d1_seg", 32'(seg), 32'hB0); end
        23: begin check("d2_sel", 32'(sel), 32'hB); check("d2_seg", 32'(seg), 32'h08); end
        33: begin check("d3_sel", 32'(sel), 32'h7); check("d3_seg", 32'(seg), 32'hF9); end
        default: ;
      endcase
    end

    wait_rdy("rdy_before_lz");
    pulse_vld(16'h0005, 4'b0000);
    wait_rdy("rdy_return_lz");
    for (int k = 1; k <= 23; k++) begin
      @(negedge sys_clk);
      case (k)
        3:  begin check("lz_d0_sel", 32'(sel), 32'hE); check("lz_d0_seg", 32'(seg), 32'h92); end
`ifdef SEG_BLANK_LZ_EN
        13: begin check("lz_d1_sel", 32'(sel), 32'hD); check("lz_d1_seg", 32'(seg), 32'hFF); end
        23: begin check("lz_d2_sel", 32'(sel), 32'hB); check("lz_d2_seg", 32'(seg), 32'hFF); end
`else
        13: begin check("lz_d1_sel", 32'(sel), 32'hD); check("lz_d1_seg", 32'(seg), 32'hC0); end
        23: begin check("lz_d2_sel", 32'(sel), 32'hB); check("lz_d2_seg", 32'(seg), 32'hC0); end
`endif
        default: ;
      endcase
    end

    pulse_vld(16'h4321, 4'b1010);
    @(negedge sys_clk);
    sys_rst = 1'b1;
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    check("midrst_rdy", 32'(data_rdy), 32'd1);
    check("midrst_sel", 32'(sel), 32'hF);
    repeat (90) @(negedge sys_clk);

    for (int c = 0; c < 3000; c++) begin
      data_vld = ($urandom_range(0, 3) == 0);
      data_in  = 16'($urandom);
      dp_in    = 4'($urandom);
      disp_en  = ($urandom_range(0, 7) != 0);
      sys_rst  = ($urandom_range(0, 699) == 0);
      @(negedge sys_clk);
    end
    sys_rst = 1'b0; data_vld = 1'b0;
    repeat (5) @(negedge sys_clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
